// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, halt/illegal
// detection, hazard stall and a saturating fetched-instruction counter.
module fetch_stage #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_id_valid,
    output logic [3:0]         if_id_opcode,
    output logic [3:0]         if_id_rd,
    output logic [3:0]         if_id_rs1,
    output logic [3:0]         if_id_rs2,
    output logic [7:0]         if_id_imm,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [3:0] OP_ILL = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic               valid_reg, valid_next;
    logic [3:0]         opcode_reg, opcode_next;
    logic [3:0]         rd_reg, rd_next;
    logic [3:0]         rs1_reg, rs1_next;
    logic [3:0]         rs2_reg, rs2_next;
    logic [7:0]         imm_reg, imm_next;
    logic [PC_W-1:0]    ipc_reg, ipc_next;
    logic               illegal_reg, illegal_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [3:0]         fetched_op;
    logic               stop_op;

    assign fetched_op = imem_data[15:12];
    assign stop_op    = (fetched_op == OP_HLT) || (fetched_op == OP_ILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FETCH;
            pc_reg      <= PC_W'(RESET_PC);
            valid_reg   <= 1'b0;
            opcode_reg  <= 4'd0;
            rd_reg      <= 4'd0;
            rs1_reg     <= 4'd0;
            rs2_reg     <= 4'd0;
            imm_reg     <= 8'd0;
            ipc_reg     <= '0;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            valid_reg   <= valid_next;
            opcode_reg  <= opcode_next;
            rd_reg      <= rd_next;
            rs1_reg     <= rs1_next;
            rs2_reg     <= rs2_next;
            imm_reg     <= imm_next;
            ipc_reg     <= ipc_next;
            illegal_reg <= illegal_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        valid_next   = valid_reg;
        opcode_next  = opcode_reg;
        rd_next      = rd_reg;
        rs1_next     = rs1_reg;
        rs2_next     = rs2_reg;
        imm_next     = imm_reg;
        ipc_next     = ipc_reg;
        illegal_next = illegal_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            FETCH: begin
                if (!stall) begin
                    if (stop_op) begin
                        // HLT/illegal become a bubble; PC stays on the stopping word
                        state_next  = HALTED;
                        valid_next  = 1'b0;
                        opcode_next = 4'd0;
                        rd_next     = 4'd0;
                        rs1_next    = 4'd0;
                        rs2_next    = 4'd0;
                        imm_next    = 8'd0;
                        ipc_next    = '0;
                        if (fetched_op == OP_ILL) begin
                            illegal_next = 1'b1;
                        end
                    end else begin
                        valid_next  = 1'b1;
                        opcode_next = imem_data[15:12];
                        rd_next     = imem_data[11:8];
                        rs1_next    = imem_data[7:4];
                        rs2_next    = imem_data[3:0];
                        imm_next    = imem_data[7:0];
                        ipc_next    = pc_reg;
                        pc_next     = pc_reg + PC_W'(1);
                        if (cnt_reg != {CNT_W{1'b1}}) begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
            end
            HALTED: begin
                valid_next  = 1'b0;
                opcode_next = 4'd0;
                rd_next     = 4'd0;
                rs1_next    = 4'd0;
                rs2_next    = 4'd0;
                imm_next    = 8'd0;
                ipc_next    = '0;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign imem_addr    = pc_reg;
    assign if_id_valid  = valid_reg;
    assign if_id_opcode = opcode_reg;
    assign if_id_rd     = rd_reg;
    assign if_id_rs1    = rs1_reg;
    assign if_id_rs2    = rs2_reg;
    assign if_id_imm    = imm_reg;
    assign if_id_pc     = ipc_reg;
    assign halted       = (state_reg == HALTED);
    assign illegal      = illegal_reg;
    assign fetch_count  = cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an instruction-level model checked every cycle on
// two configurations, plus hand-computed checks from the directed scenarios.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall0 = 1'b0;
    logic        stall1 = 1'b0;
    logic        check_en = 1'b0;

    logic [15:0] rom0 [256];
    logic [15:0] rom1 [4];

    logic [7:0]  addr0;
    logic [15:0] data0;
    logic        valid0, halted0, illegal0;
    logic [3:0]  op0, rd0, rs10, rs20;
    logic [7:0]  imm0, ipc0;
    logic [15:0] cnt0;

    logic [1:0]  addr1;
    logic [15:0] data1;
    logic        valid1, halted1, illegal1;
    logic [3:0]  op1, rd1, rs11, rs21;
    logic [7:0]  imm1;
    logic [1:0]  ipc1;
    logic [1:0]  cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance: [0] = 8-bit PC/16-bit count, [1] = 2-bit/2-bit
    int m_pc [2];
    int m_valid [2];
    int m_instr [2];
    int m_ipc [2];
    int m_halt [2];
    int m_ill [2];
    int m_cnt [2];
    int pc_mod [2] = '{256, 4};
    int cnt_max [2] = '{65535, 3};

    assign data0 = rom0[addr0];
    assign data1 = rom1[addr1];

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .stall(stall0),
        .imem_addr(addr0), .imem_data(data0),
        .if_id_valid(valid0), .if_id_opcode(op0), .if_id_rd(rd0),
        .if_id_rs1(rs10), .if_id_rs2(rs20), .if_id_imm(imm0),
        .if_id_pc(ipc0), .halted(halted0), .illegal(illegal0),
        .fetch_count(cnt0)
    );

    fetch_stage #(.PC_W(2), .INSTR_W(16), .RESET_PC(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .stall(stall1),
        .imem_addr(addr1), .imem_data(data1),
        .if_id_valid(valid1), .if_id_opcode(op1), .if_id_rd(rd1),
        .if_id_rs1(rs11), .if_id_rs2(rs21), .if_id_imm(imm1),
        .if_id_pc(ipc1), .halted(halted1), .illegal(illegal1),
        .fetch_count(cnt1)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_valid[i] = 0; m_instr[i] = 0; m_ipc[i] = 0;
            m_halt[i] = 0; m_ill[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input logic st, input logic [15:0] instr);
        int op;
        op = int'(instr) / 4096;
        if (m_halt[i] != 0 || st) return;
        if (op >= 14) begin
            m_valid[i] = 0; m_instr[i] = 0; m_ipc[i] = 0; m_halt[i] = 1;
            if (op == 14) m_ill[i] = 1;
        end else begin
            m_valid[i] = 1;
            m_instr[i] = int'(instr);
            m_ipc[i] = m_pc[i];
            m_pc[i] = (m_pc[i] + 1) % pc_mod[i];
            if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, stall0, rom0[m_pc[0]]);
        model_edge(1, stall1, rom1[m_pc[1]]);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("m0_addr",  32'(addr0),    32'(m_pc[0]));
            chk("m0_valid", 32'(valid0),   32'(m_valid[0]));
            chk("m0_op",    32'(op0),      32'((m_instr[0] >> 12) % 16));
            chk("m0_rd",    32'(rd0),      32'((m_instr[0] >> 8) % 16));
            chk("m0_rs1",   32'(rs10),     32'((m_instr[0] >> 4) % 16));
            chk("m0_rs2",   32'(rs20),     32'(m_instr[0] % 16));
            chk("m0_imm",   32'(imm0),     32'(m_instr[0] % 256));
            chk("m0_ipc",   32'(ipc0),     32'(m_ipc[0]));
            chk("m0_halt",  32'(halted0),  32'(m_halt[0]));
            chk("m0_ill",   32'(illegal0), 32'(m_ill[0]));
            chk("m0_cnt",   32'(cnt0),     32'(m_cnt[0]));
            chk("m1_addr",  32'(addr1),    32'(m_pc[1]));
            chk("m1_valid", 32'(valid1),   32'(m_valid[1]));
            chk("m1_op",    32'(op1),      32'((m_instr[1] >> 12) % 16));
            chk("m1_imm",   32'(imm1),     32'(m_instr[1] % 256));
            chk("m1_ipc",   32'(ipc1),     32'(m_ipc[1]));
            chk("m1_halt",  32'(halted1),  32'(m_halt[1]));
            chk("m1_cnt",   32'(cnt1),     32'(m_cnt[1]));
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom0[i] = 16'h0000;
        for (int i = 0; i < 4; i++) rom1[i] = 16'h1A00 + 16'(i);
        model_reset();
        #1;
        chk("rst_addr", 32'(addr0), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);
        chk("rst_halt", 32'(halted0), 32'h0);
        chk("rst_cnt", 32'(cnt0), 32'h0);

        // reset and run
        rom0[0] = 16'h2A12; rom0[1] = 16'hA345; rom0[2] = 16'hF000;
        do_reset();
        check_en = 1'b1;
        tick();
        chk("run1_valid", 32'(valid0), 32'h1);
        chk("run1_op", 32'(op0), 32'h2);
        chk("run1_rd", 32'(rd0), 32'hA);
        chk("run1_rs1", 32'(rs10), 32'h1);
        chk("run1_rs2", 32'(rs20), 32'h2);
        chk("run1_pc", 32'(ipc0), 32'h0);
        tick();
        chk("run2_op", 32'(op0), 32'hA);
        chk("run2_imm", 32'(imm0), 32'h45);
        chk("run2_pc", 32'(ipc0), 32'h1);
        tick();
        chk("run3_valid", 32'(valid0), 32'h0);
        chk("run3_halt", 32'(halted0), 32'h1);
        chk("run3_addr", 32'(addr0), 32'h2);
        chk("run3_cnt", 32'(cnt0), 32'h2);

        // two-cycle stall at PC=1
        rom0[0] = 16'h1011; rom0[1] = 16'h2122; rom0[2] = 16'h3233; rom0[3] = 16'hF000;
        do_reset();
        tick();
        stall0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_addr", 32'(addr0), 32'h1);
            chk("stall_pc", 32'(ipc0), 32'h0);
            chk("stall_op", 32'(op0), 32'h1);
            chk("stall_cnt", 32'(cnt0), 32'h1);
        end
        stall0 = 1'b0;
        tick();
        chk("resume_pc", 32'(ipc0), 32'h1);
        chk("resume_op", 32'(op0), 32'h2);
        chk("resume_cnt", 32'(cnt0), 32'h2);
        tick();
        chk("resume2_cnt", 32'(cnt0), 32'h3);
        tick();
        chk("stall_end_halt", 32'(halted0), 32'h1);
        chk("stall_end_addr", 32'(addr0), 32'h3);
        chk("stall_end_cnt", 32'(cnt0), 32'h3);

        // stall while HLT is presented
        rom0[0] = 16'h4444; rom0[1] = 16'hF000;
        do_reset();
        tick();
        stall0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("sthlt_halt", 32'(halted0), 32'h0);
            chk("sthlt_valid", 32'(valid0), 32'h1);
            chk("sthlt_addr", 32'(addr0), 32'h1);
        end
        stall0 = 1'b0;
        tick();
        chk("sthlt_rise", 32'(halted0), 32'h1);
        chk("sthlt_bubble", 32'(valid0), 32'h0);

        // illegal opcode, then stall toggling while halted
        rom0[0] = 16'hE123;
        do_reset();
        tick();
        chk("ill_halt", 32'(halted0), 32'h1);
        chk("ill_flag", 32'(illegal0), 32'h1);
        chk("ill_valid", 32'(valid0), 32'h0);
        for (int k = 0; k < 4; k++) begin
            stall0 = ~stall0;
            tick();
            chk("ill_hold_addr", 32'(addr0), 32'h0);
            chk("ill_hold_cnt", 32'(cnt0), 32'h0);
            chk("ill_hold_halt", 32'(halted0), 32'h1);
            chk("ill_hold_flag", 32'(illegal0), 32'h1);
        end
        stall0 = 1'b0;

        // PC wrap and counter saturation on the 2-bit instance
        for (int i = 0; i < 8; i++) rom0[i] = 16'h6000 + 16'(i);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("wrap_pc", 32'(ipc1), 32'(k % 4));
            chk("wrap_cnt", 32'(cnt1), 32'((k < 3) ? k + 1 : 3));
            chk("wrap_valid", 32'(valid1), 32'h1);
        end

        // asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid0), 32'h0);
        chk("arst_addr", 32'(addr0), 32'h0);
        chk("arst_cnt", 32'(cnt0), 32'h0);
        chk("arst_ipc", 32'(ipc0), 32'h0);
        chk("arst_op", 32'(op0), 32'h0);
        chk("arst_cnt1", 32'(cnt1), 32'h0);
        model_reset();
        #1;
        rst = 1'b0;
        tick();
        chk("arst_cap_pc", 32'(ipc0), 32'h0);
        chk("arst_cap_op", 32'(op0), 32'h6);
        chk("arst_cap_rs2", 32'(rs20), 32'h0);
        chk("arst_cap_valid", 32'(valid0), 32'h1);
        chk("arst_cap_pc1", 32'(ipc1), 32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
